fetch_sequencer: RTL and testbench

- Sequences the 128-word instruction memory: owns the program counter, drives the memory word address, and captures the returned instruction into the IF/ID pipeline register.
- Handles pipeline stall, branch/jump redirect with flush, halt, and address faults.
- Sits between the hazard/branch logic and the decode stage of the single-issue MIPS pipeline.
- The instruction memory is combinational (read data valid in the same cycle as the address) and is word-indexed by address bits [8:2].

---
 rtl/fetch_sequencer.sv | 102 ++++++++++
 tb/tb_fetch_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, addresses the combinational instruction
// memory and captures the returned word into the IF/ID pipeline register.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 128,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic [31:0]      ImemAddress,
  input  logic [31:0]      ImemInstruction,
  input  logic             Stall,
  input  logic             Redirect,
  input  logic [31:0]      RedirectTarget,
  input  logic             Halt,
  output logic [31:0]      IfIdInstruction,
  output logic [31:0]      IfIdPCPlus4,
  output logic             IfIdValid,
  output logic [1:0]       State,
  output logic             Fault,
  output logic [CNT_W-1:0] FetchCount,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StHalted = 2'b10,
    StFault  = 2'b11
  } state_e;

  localparam logic [31:0]      ImemBytes = 32'(IMEM_WORDS * 4);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic        target_legal;

  assign pc_plus4     = pc_q + 32'd4;
  assign target_legal = (RedirectTarget[1:0] == 2'b00) && (RedirectTarget < ImemBytes);

  assign ImemAddress = pc_q;
  assign State       = state_q;
  assign Fault       = (state_q == StFault);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q         <= StIdle;
      pc_q            <= RESET_PC;
      IfIdInstruction <= 32'd0;
      IfIdPCPlus4     <= 32'd0;
      IfIdValid       <= 1'b0;
      FetchCount      <= '0;
      StallCount      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= Halt ? StHalted : StRun;
        end
        StRun: begin
          if (Halt) begin
            state_q         <= StHalted;
            IfIdValid       <= 1'b0;
            IfIdInstruction <= 32'd0;
          end else if (Redirect) begin
            // A redirect always flushes, so a concurrent Stall is dropped uncounted.
            IfIdValid       <= 1'b0;
            IfIdInstruction <= 32'd0;
            if (target_legal) begin
              pc_q <= RedirectTarget;
            end else begin
              state_q <= StFault;
            end
          end else if (Stall) begin
            if (StallCount != CntMax) StallCount <= StallCount + CntOne;
          end else begin
            IfIdInstruction <= ImemInstruction;
            IfIdPCPlus4     <= pc_plus4;
            IfIdValid       <= 1'b1;
            if (FetchCount != CntMax) FetchCount <= FetchCount + CntOne;
            // Fetching the last word runs off the end of memory: keep it, then fault.
            if (pc_plus4 < ImemBytes) begin
              pc_q <= pc_plus4;
            end else begin
              state_q <= StFault;
            end
          end
        end
        StHalted, StFault: begin
          IfIdValid       <= 1'b0;
          IfIdInstruction <= 32'd0;
        end
        default: begin
          state_q <= StFault;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected IF/ID words are queued by the stimulus
// and checked by an independent monitor; control/status is checked inline.
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] ImemAddress;
  logic [31:0] ImemInstruction;
  logic        Stall = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectTarget = 32'd0;
  logic        Halt = 1'b0;
  logic [31:0] IfIdInstruction;
  logic [31:0] IfIdPCPlus4;
  logic        IfIdValid;
  logic [1:0]  State;
  logic        Fault;
  logic [15:0] FetchCount;
  logic [15:0] StallCount;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  fetch_sequencer #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(128),
    .CNT_W     (16)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ImemAddress    (ImemAddress),
    .ImemInstruction(ImemInstruction),
    .Stall          (Stall),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .Halt           (Halt),
    .IfIdInstruction(IfIdInstruction),
    .IfIdPCPlus4    (IfIdPCPlus4),
    .IfIdValid      (IfIdValid),
    .State          (State),
    .Fault          (Fault),
    .FetchCount     (FetchCount),
    .StallCount     (StallCount)
  );

  always #5 Clk = ~Clk;

  // memory[i] = i*3
  assign ImemInstruction = 32'(ImemAddress[8:2]) * 32'd3;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h, want %0h", name, got, want);
  endtask

  // Monitor: every cycle with IfIdValid high must match the next queued expectation.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (IfIdValid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL ifid_unexpected: got %0h/%0h valid, want no valid word",
                   IfIdInstruction, IfIdPCPlus4);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (IfIdInstruction === e.instr && IfIdPCPlus4 === e.pc4) passes++;
          else $display("FAIL ifid_word: got %0h/%0h, want %0h/%0h",
                        IfIdInstruction, IfIdPCPlus4, e.instr, e.pc4);
        end
      end else if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        $display("FAIL ifid_missing: got valid=%b, want %0h/%0h", IfIdValid, e.instr, e.pc4);
      end
    end
  end

  // One cycle: drive inputs, queue the IF/ID word expected after the edge (if any).
  task automatic step(input logic s, input logic r, input logic [31:0] t, input logic h,
                      input bit ev, input logic [31:0] ei, input logic [31:0] ep);
    exp_t e;
    #1;
    Stall = s; Redirect = r; RedirectTarget = t; Halt = h;
    if (ev) begin
      e.instr = ei;
      e.pc4   = ep;
      exp_q.push_back(e);
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk_reset_values();
    chk("rst_pc", ImemAddress, 32'h0);
    chk("rst_state", 32'(State), 32'h0);
    chk("rst_valid", 32'(IfIdValid), 32'h0);
    chk("rst_instr", IfIdInstruction, 32'h0);
    chk("rst_pc4", IfIdPCPlus4, 32'h0);
    chk("rst_fault", 32'(Fault), 32'h0);
    chk("rst_fetchcnt", 32'(FetchCount), 32'h0);
    chk("rst_stallcnt", 32'(StallCount), 32'h0);
  endtask

  // Asserts Reset mid-cycle and checks it takes effect without a clock edge.
  task automatic do_reset();
    #3;
    Reset = 1'b1;
    Stall = 1'b0; Redirect = 1'b0; RedirectTarget = 32'd0; Halt = 1'b0;
    #1;
    chk_reset_values();
    exp_q.delete();
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    chk_reset_values();
    Reset = 1'b0;

    // Sequential fetch, then a 3-cycle stall at PC=8.
    step(0, 0, 0, 0, 0, 0, 0);
    chk("idle_to_run", 32'(State), 32'h1);
    chk("idle_no_fetch", ImemAddress, 32'h0);
    step(0, 0, 0, 0, 1, 0, 4);
    step(0, 0, 0, 0, 1, 3, 8);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 3, 8);
    chk("stall_pc", ImemAddress, 32'h8);
    chk("stall_cnt", 32'(StallCount), 32'd3);
    chk("stall_fetchcnt", 32'(FetchCount), 32'd2);
    step(0, 0, 0, 0, 1, 6, 12);
    chk("fetchcnt3", 32'(FetchCount), 32'd3);

    // Redirect with Stall at PC=0x0C: one bubble, stall not counted.
    step(1, 1, 32'h40, 0, 0, 0, 0);
    chk("redir_pc", ImemAddress, 32'h40);
    chk("redir_stallcnt", 32'(StallCount), 32'd3);
    step(0, 0, 0, 0, 1, 48, 32'h44);
    chk("redir_fetchcnt", 32'(FetchCount), 32'd4);

    // Misaligned redirect: fault, then everything frozen.
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 4);
    step(0, 1, 32'h42, 0, 0, 0, 0);
    chk("misalign_state", 32'(State), 32'h3);
    chk("misalign_fault", 32'(Fault), 32'h1);
    for (int i = 0; i < 10; i++) step(i[0], i[1], 32'h40, i[2], 0, 0, 0);
    chk("fault_pc_frozen", ImemAddress, 32'h4);
    chk("fault_fetchcnt", 32'(FetchCount), 32'd1);
    chk("fault_stallcnt", 32'(StallCount), 32'd0);
    chk("fault_state_held", 32'(State), 32'h3);

    // Out-of-range redirect.
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h200, 0, 0, 0, 0);
    chk("oor_state", 32'(State), 32'h3);
    chk("oor_pc", ImemAddress, 32'h0);

    // Run off the end of memory: last word latched, then FAULT at PC=0x1FC.
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h1F8, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 378, 32'h1FC);
    chk("end_pc", ImemAddress, 32'h1FC);
    step(0, 0, 0, 0, 1, 381, 32'h200);
    chk("end_state", 32'(State), 32'h3);
    chk("end_pc_held", ImemAddress, 32'h1FC);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("end_valid_clear", 32'(IfIdValid), 32'h0);
    chk("end_fetchcnt", 32'(FetchCount), 32'd2);
    do_reset();

    // Halt beats Redirect in RUN; later pulses ignored.
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 4);
    step(0, 1, 32'h40, 1, 0, 0, 0);
    chk("halt_state", 32'(State), 32'h2);
    chk("halt_pc", ImemAddress, 32'h4);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h20, 0, 0, 0, 0);
    chk("halt_pc_frozen", ImemAddress, 32'h4);
    chk("halt_stallcnt", 32'(StallCount), 32'd0);
    chk("halt_state_held", 32'(State), 32'h2);

    // Halt during IDLE.
    do_reset();
    step(0, 0, 0, 1, 0, 0, 0);
    chk("idle_halt_state", 32'(State), 32'h2);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("idle_halt_pc", ImemAddress, 32'h0);

    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL leftover_expect: got %0d unconsumed, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
